// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: streams words from instruction memory into a small
// prefetch queue and hands them to ID, with redirect flush, halt and HLT pre-decode.
module ifetch_prefetch #(
  parameter int DEPTH    = 4,
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int RESET_PC = 0,
  parameter int PC_MAX   = 400
) (
  input  logic                     clk1,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_rvalid,
  input  logic [DW-1:0]            imem_rdata,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [DW-1:0]            id_instr,
  output logic [AW-1:0]            id_pc,
  input  logic                     br_taken,
  input  logic [AW-1:0]            br_target,
  input  logic                     halt,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fetch_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [AW-1:0] PC_MAX_A   = AW'(PC_MAX);
  localparam logic [AW-1:0] RESET_PC_A = AW'(RESET_PC);
  localparam logic [4:0]    OP_HLT     = 5'b10111;

  function automatic logic is_hlt(input logic [DW-1:0] word);
    return (word[14:10] == OP_HLT);
  endfunction

  function automatic logic [AW-1:0] pc_inc(input logic [AW-1:0] addr);
    return (addr == PC_MAX_A) ? {AW{1'b0}} : addr + AW'(1);
  endfunction

  logic [AW-1:0] pc_r;
  logic [AW-1:0] req_addr_r;
  logic          inflight_r;
  logic          kill_r;
  logic          stopped_r;
  logic          fetch_err_r;
  logic [DW-1:0] instr_mem_r [DEPTH];
  logic [AW-1:0] pc_mem_r    [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          id_valid_r;
  logic [DW-1:0] id_instr_r;
  logic [AW-1:0] id_pc_r;

  logic          issue_s;
  logic          push_s;
  logic          pop_s;
  logic          hlt_push_s;
  logic          br_bad_s;
  logic [CW:0]   occ_s;
  logic [CW-1:0] remain_s;
  logic [CW-1:0] count_n_s;
  logic [PW-1:0] rd_n_s;
  logic [DW-1:0] head_instr_s;
  logic [AW-1:0] head_pc_s;

  // Issue/push/pop decisions and the next head entry presented to ID.
  always_comb begin
    occ_s      = {1'b0, count_r} + (CW+1)'(inflight_r);
    issue_s    = !rst && !stopped_r && !halt && !br_taken && (occ_s < (CW+1)'(DEPTH));
    push_s     = imem_rvalid && inflight_r && !kill_r && !br_taken;
    pop_s      = id_valid_r && id_ready && !br_taken;
    hlt_push_s = push_s && is_hlt(imem_rdata);
    br_bad_s   = br_taken && (br_target > PC_MAX_A);
    remain_s   = count_r - CW'(pop_s);
    count_n_s  = remain_s + CW'(push_s);
    rd_n_s     = rd_ptr_r + PW'(pop_s);
    // An otherwise-empty queue exposes the word being pushed this cycle.
    if (remain_s == {CW{1'b0}}) begin
      head_instr_s = imem_rdata;
      head_pc_s    = req_addr_r;
    end else begin
      head_instr_s = instr_mem_r[rd_n_s];
      head_pc_s    = pc_mem_r[rd_n_s];
    end
  end

  // PC, fetch control flags, prefetch queue and registered ID-side outputs.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_PC_A;
      req_addr_r  <= {AW{1'b0}};
      inflight_r  <= 1'b0;
      kill_r      <= 1'b0;
      stopped_r   <= 1'b0;
      fetch_err_r <= 1'b0;
      wr_ptr_r    <= {PW{1'b0}};
      rd_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      id_valid_r  <= 1'b0;
      id_instr_r  <= {DW{1'b0}};
      id_pc_r     <= {AW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_r[i] <= {DW{1'b0}};
        pc_mem_r[i]    <= {AW{1'b0}};
      end
    end else begin
      inflight_r  <= issue_s;
      kill_r      <= br_taken;
      fetch_err_r <= fetch_err_r | br_bad_s;
      if (issue_s) begin
        req_addr_r <= pc_r;
      end
      if (br_taken) begin
        pc_r      <= br_target;
        stopped_r <= br_bad_s;
        wr_ptr_r  <= {PW{1'b0}};
        rd_ptr_r  <= {PW{1'b0}};
        count_r   <= {CW{1'b0}};
        id_valid_r <= 1'b0;
      end else begin
        if (issue_s) begin
          pc_r <= pc_inc(pc_r);
        end
        if (hlt_push_s) begin
          stopped_r <= 1'b1;
        end
        if (push_s) begin
          instr_mem_r[wr_ptr_r] <= imem_rdata;
          pc_mem_r[wr_ptr_r]    <= req_addr_r;
          wr_ptr_r              <= wr_ptr_r + PW'(1);
        end
        rd_ptr_r   <= rd_n_s;
        count_r    <= count_n_s;
        id_valid_r <= (count_n_s != {CW{1'b0}});
        if (count_n_s != {CW{1'b0}}) begin
          id_instr_r <= head_instr_s;
          id_pc_r    <= head_pc_s;
        end
      end
    end
  end

  assign imem_req   = issue_s;
  assign imem_addr  = pc_r;
  assign id_valid   = id_valid_r;
  assign id_instr   = id_instr_r;
  assign id_pc      = id_pc_r;
  assign fifo_count = count_r;
  assign fetch_err  = fetch_err_r;

endmodule
